// File: rtl/dma_pkg.sv
// Shared types and register map for the word-copy DMA engine.
// State encoding, register indices, CTRL/STATUS bit positions.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT
  } dma_state_t;

  localparam int REG_SRC    = 0;
  localparam int REG_DST    = 1;
  localparam int REG_LEN    = 2;
  localparam int REG_CTRL   = 3;
  localparam int REG_STATUS = 4;
  localparam int REG_COUNT  = 5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_ABORTED = 3;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dma_regfile.sv
// Slave register window of the DMA engine: decode, storage, W1C status.
// DMA_IRQ_EN adds the writable CTRL.IRQ_EN bit and the irq output.
module dma_regfile
  import dma_pkg::*;
#(
  parameter int WORD_ADDR_BITS = 4,
  parameter int LEN_BITS       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WORD_ADDR_BITS-1:0] read_addr,
  input  logic                      oe,
  output logic [31:0]               data_out,
  output logic                      data_valid,
  input  logic [WORD_ADDR_BITS-1:0] write_addr,
  input  logic [31:0]               data_in,
  input  logic [3:0]                be,
  input  logic                      we,
  output logic                      wack,
  input  logic                      busy,
  input  logic [LEN_BITS-1:0]       count,
  input  logic                      done_set,
  input  logic                      err_set,
  input  logic                      abort_set,
  input  logic                      clr_status,
  output logic [31:0]               src,
  output logic [31:0]               dst,
  output logic [LEN_BITS-1:0]       len,
  output logic                      start_req,
  output logic                      abort_req
`ifdef DMA_IRQ_EN
  ,
  output logic                      irq
`endif
);

  logic wr_src, wr_dst, wr_len;
  logic wr_ctrl, wr_stat;
  logic clr_done, clr_err, clr_abt;
  logic done_q, err_q, abt_q;
  logic irq_en_q;
  logic [31:0] rd_mux;

  assign wr_src  = we && (write_addr == WORD_ADDR_BITS'(REG_SRC));
  assign wr_dst  = we && (write_addr == WORD_ADDR_BITS'(REG_DST));
  assign wr_len  = we && (write_addr == WORD_ADDR_BITS'(REG_LEN));
  assign wr_ctrl = we && (write_addr == WORD_ADDR_BITS'(REG_CTRL)) && be[0];
  assign wr_stat = we && (write_addr == WORD_ADDR_BITS'(REG_STATUS)) && be[0];

  assign clr_done = wr_stat & data_in[ST_DONE];
  assign clr_err  = wr_stat & data_in[ST_ERR];
  assign clr_abt  = wr_stat & data_in[ST_ABORTED];

  always_comb begin
    rd_mux = '0;
    case (read_addr)
      WORD_ADDR_BITS'(REG_SRC):    rd_mux = src;
      WORD_ADDR_BITS'(REG_DST):    rd_mux = dst;
      WORD_ADDR_BITS'(REG_LEN):    rd_mux = 32'(len);
      WORD_ADDR_BITS'(REG_CTRL):   rd_mux[CTRL_IRQ_EN] = irq_en_q;
      WORD_ADDR_BITS'(REG_STATUS): rd_mux[3:0] = {abt_q, err_q, done_q, busy};
      WORD_ADDR_BITS'(REG_COUNT):  rd_mux = 32'(count);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      wack       <= 1'b0;
      start_req  <= 1'b0;
      abort_req  <= 1'b0;
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abt_q      <= 1'b0;
    end else begin
      data_valid <= oe;
      data_out   <= oe ? rd_mux : '0;
      wack       <= we;
      start_req  <= wr_ctrl & data_in[CTRL_START];
      abort_req  <= wr_ctrl & data_in[CTRL_ABORT];
      // Programming registers are frozen for the whole transfer
      if (wr_src && !busy) src <= be_merge(src, data_in, be) & 32'hFFFF_FFFC;
      if (wr_dst && !busy) dst <= be_merge(dst, data_in, be) & 32'hFFFF_FFFC;
      if (wr_len && !busy) begin
        for (int i = 0; i < LEN_BITS; i++) begin
          if (be[i/8]) len[i] <= data_in[i];
        end
      end
      // Hardware set beats a same-cycle W1C
      done_q <= done_set  | (done_q & ~(clr_done | clr_status));
      err_q  <= err_set   | (err_q  & ~(clr_err  | clr_status));
      abt_q  <= abort_set | (abt_q  & ~(clr_abt  | clr_status));
    end
  end

`ifdef DMA_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en_q <= data_in[CTRL_IRQ_EN];
    end
  end

  assign irq = done_q & irq_en_q;
`else
  assign irq_en_q = 1'b0;
`endif

endmodule

// File: rtl/dma_copy_engine.sv
// Word-copy DMA: slave register window plus a single-outstanding bus master.
// Define DMA_IRQ_EN to get the irq_o done interrupt.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int WORD_ADDR_BITS = 4,
  parameter int LEN_BITS       = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [WORD_ADDR_BITS-1:0] READ_ADDR,
  input  logic                      OE,
  output logic [31:0]               DATA_OUT,
  output logic                      DATA_VALID,
  input  logic [WORD_ADDR_BITS-1:0] WRITE_ADDR,
  input  logic [31:0]               DATA_IN,
  input  logic [3:0]                BE,
  input  logic                      WE,
  output logic                      WACK,
  output logic                      m_req_o,
  input  logic                      m_gnt_i,
  input  logic                      m_rvalid_i,
  input  logic                      m_err_i,
  output logic                      m_we_o,
  output logic [3:0]                m_be_o,
  output logic [31:0]               m_addr_o,
  output logic [31:0]               m_wdata_o,
  input  logic [31:0]               m_rdata_i
`ifdef DMA_IRQ_EN
  ,
  output logic                      irq_o
`endif
);

  logic start_req, abort_req;
  logic done_set, err_set, abort_set;
  logic clr_status, busy;
  logic [31:0] src, dst;
  logic [LEN_BITS-1:0] len;

  dma_state_t state_q, state_d;
  logic [31:0] src_ptr, dst_ptr, dbuf_q;
  logic [LEN_BITS-1:0] count_q;
  logic abort_pend_q, abort_now, last_beat;
  logic launch, rd_cap, wr_adv;
  logic rd_ph, wr_ph;

  dma_regfile #(
    .WORD_ADDR_BITS(WORD_ADDR_BITS),
    .LEN_BITS      (LEN_BITS)
  ) u_regfile (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .read_addr (READ_ADDR),
    .oe        (OE),
    .data_out  (DATA_OUT),
    .data_valid(DATA_VALID),
    .write_addr(WRITE_ADDR),
    .data_in   (DATA_IN),
    .be        (BE),
    .we        (WE),
    .wack      (WACK),
    .busy      (busy),
    .count     (count_q),
    .done_set  (done_set),
    .err_set   (err_set),
    .abort_set (abort_set),
    .clr_status(clr_status),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .start_req (start_req),
    .abort_req (abort_req)
`ifdef DMA_IRQ_EN
    ,
    .irq       (irq_o)
`endif
  );

  assign busy      = state_q != S_IDLE;
  assign abort_now = abort_pend_q | abort_req;
  assign last_beat = count_q == LEN_BITS'(1);

  assign rd_ph = (state_q == S_RD_REQ) | (state_q == S_RD_WAIT);
  assign wr_ph = (state_q == S_WR_REQ) | (state_q == S_WR_WAIT);

  assign m_req_o   = (state_q == S_RD_REQ) | (state_q == S_WR_REQ);
  assign m_we_o    = wr_ph;
  assign m_be_o    = {4{busy}};
  assign m_addr_o  = rd_ph ? src_ptr : (wr_ph ? dst_ptr : '0);
  assign m_wdata_o = wr_ph ? dbuf_q : '0;

  always_comb begin
    state_d    = state_q;
    done_set   = 1'b0;
    err_set    = 1'b0;
    abort_set  = 1'b0;
    clr_status = 1'b0;
    launch     = 1'b0;
    rd_cap     = 1'b0;
    wr_adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          if (len != '0) begin
            launch     = 1'b1;
            clr_status = 1'b1;
            state_d    = S_RD_REQ;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        if (m_gnt_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (m_rvalid_i) begin
          if (m_err_i) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end else begin
            rd_cap = 1'b1;
            if (abort_now) begin
              abort_set = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d = S_WR_REQ;
            end
          end
        end
      end
      S_WR_REQ: begin
        if (m_gnt_i) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (m_rvalid_i) begin
          if (m_err_i) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end else begin
            wr_adv = 1'b1;
            // A completed final word counts as done even if abort is pending
            if (last_beat) begin
              done_set = 1'b1;
              state_d  = S_IDLE;
            end else if (abort_now) begin
              abort_set = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d = S_RD_REQ;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      abort_pend_q <= 1'b0;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      dbuf_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      abort_pend_q <= (state_d != S_IDLE) & (abort_pend_q | (abort_req & busy));
      if (launch) begin
        src_ptr <= src;
        dst_ptr <= dst;
        count_q <= len;
      end else if (wr_adv) begin
        src_ptr <= src_ptr + 32'd4;
        dst_ptr <= dst_ptr + 32'd4;
        count_q <= count_q - LEN_BITS'(1);
      end
      if (rd_cap) dbuf_q <= m_rdata_i;
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine with a queue-based bus model.
// Irq checks are compiled in when DMA_IRQ_EN is defined.
module tb_dma_copy_engine;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  READ_ADDR = '0;
  logic        OE = 1'b0;
  logic [31:0] DATA_OUT;
  logic        DATA_VALID;
  logic [3:0]  WRITE_ADDR = '0;
  logic [31:0] DATA_IN = '0;
  logic [3:0]  BE = '0;
  logic        WE = 1'b0;
  logic        WACK;
  logic        m_req_o;
  logic        m_gnt_i = 1'b0;
  logic        m_rvalid_i = 1'b0;
  logic        m_err_i = 1'b0;
  logic        m_we_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [31:0] m_rdata_i = '0;
`ifdef DMA_IRQ_EN
  logic        irq_o;
`endif

  dma_copy_engine #(.WORD_ADDR_BITS(4), .LEN_BITS(16)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .READ_ADDR (READ_ADDR),
    .OE        (OE),
    .DATA_OUT  (DATA_OUT),
    .DATA_VALID(DATA_VALID),
    .WRITE_ADDR(WRITE_ADDR),
    .DATA_IN   (DATA_IN),
    .BE        (BE),
    .WE        (WE),
    .WACK      (WACK),
    .m_req_o   (m_req_o),
    .m_gnt_i   (m_gnt_i),
    .m_rvalid_i(m_rvalid_i),
    .m_err_i   (m_err_i),
    .m_we_o    (m_we_o),
    .m_be_o    (m_be_o),
    .m_addr_o  (m_addr_o),
    .m_wdata_o (m_wdata_o),
    .m_rdata_i (m_rdata_i)
`ifdef DMA_IRQ_EN
    ,
    .irq_o     (irq_o)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [3:0] A_SRC = 4'd0, A_DST = 4'd1, A_LEN = 4'd2;
  localparam logic [3:0] A_CTRL = 4'd3, A_STAT = 4'd4, A_CNT = 4'd5;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t       exp_q[$];
  logic [31:0] rd_log[$];
  logic [31:0] mem[logic [31:0]];

  int gnt_delay = 0;
  int rsp_delay = 1;
  int err_beat  = -1;
  int beat_no   = 0;
  int n_grants  = 0;
  int wait_cnt  = 0;
  int rsp_cnt   = 0;
  bit pend      = 1'b0;
  logic        p_we, h_we;
  logic [31:0] p_addr, p_wdata, h_addr;
  beat_t       e_cur;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5EED_0000;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction

  // Expected beat sequence: read src+4i, write dst+4i, truncated at limit
  task automatic plan(input logic [31:0] src, input logic [31:0] dst,
                      input int len, input int limit);
    logic [31:0] s, d;
    int k;
    s = src; d = dst; k = 0;
    for (int i = 0; i < len; i++) begin
      if (k < limit) begin exp_q.push_back(beat_t'{1'b0, s, 32'h0}); k++; end
      if (k < limit) begin exp_q.push_back(beat_t'{1'b1, d, rd_word(s)}); k++; end
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  // Bus slave model and compare process, acting once per cycle
  always @(negedge clk) begin
    m_gnt_i    = 1'b0;
    m_rvalid_i = 1'b0;
    m_err_i    = 1'b0;
    m_rdata_i  = '0;
    if (!rst_ni) begin
      pend     = 1'b0;
      wait_cnt = 0;
    end else if (pend) begin
      rsp_cnt++;
      if (rsp_cnt >= rsp_delay) begin
        pend       = 1'b0;
        m_rvalid_i = 1'b1;
        if (beat_no == err_beat) m_err_i = 1'b1;
        else if (p_we) mem[p_addr] = p_wdata;
        else m_rdata_i = rd_word(p_addr);
        beat_no++;
      end
    end else if (m_req_o) begin
      if (wait_cnt == 0) begin
        h_addr = m_addr_o;
        h_we   = m_we_o;
      end else begin
        check("req_addr_stable", m_addr_o, h_addr);
        check("req_we_stable", 32'(m_we_o), 32'(h_we));
      end
      if (wait_cnt >= gnt_delay) begin
        m_gnt_i  = 1'b1;
        wait_cnt = 0;
        pend     = 1'b1;
        rsp_cnt  = 0;
        p_we     = m_we_o;
        p_addr   = m_addr_o;
        p_wdata  = m_wdata_o;
        n_grants++;
        if (!m_we_o) rd_log.push_back(m_addr_o);
        check("beat_be", 32'(m_be_o), 32'hF);
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'(m_req_o), 32'h0);
        end else begin
          e_cur = exp_q.pop_front();
          check("beat_we", 32'(m_we_o), 32'(e_cur.we));
          check("beat_addr", m_addr_o, e_cur.addr);
          if (e_cur.we) check("beat_wdata", m_wdata_o, e_cur.wdata);
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Slave tasks are entered and left just after a falling edge
  task automatic reg_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    WRITE_ADDR = a;
    DATA_IN    = d;
    BE         = be;
    WE         = 1'b1;
    @(negedge clk);
    check("wack", 32'(WACK), 32'h1);
    WE = 1'b0;
    BE = '0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    READ_ADDR = a;
    OE        = 1'b1;
    @(negedge clk);
    check("data_valid", 32'(DATA_VALID), 32'h1);
    d  = DATA_OUT;
    OE = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [3:0] a,
                          input logic [31:0] exp);
    logic [31:0] v;
    reg_read(a, v);
    check(name, v, exp);
  endtask

  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len, input logic [31:0] ctrl);
    reg_write(A_SRC, src, 4'hF);
    reg_write(A_DST, dst, 4'hF);
    reg_write(A_LEN, len, 4'hF);
    reg_write(A_CTRL, ctrl, 4'hF);
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    bit idle;
    idle = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      reg_read(A_STAT, st);
      if (!st[0]) begin
        idle = 1'b1;
        break;
      end
    end
    check("xfer_timeout", 32'(idle), 32'h1);
  endtask

  task automatic end_regs(input string tag, input logic [31:0] st,
                          input logic [31:0] cnt);
    read_chk({tag, "_status"}, A_STAT, st);
    read_chk({tag, "_count"}, A_CNT, cnt);
    check({tag, "_beats_left"}, exp_q.size(), 0);
  endtask

  task automatic mem_chk(input string tag, input logic [31:0] src,
                         input logic [31:0] dst, input int len);
    logic [31:0] a;
    for (int i = 0; i < len; i++) begin
      a = dst + 32'(4 * i);
      check({tag, "_dst_word"}, mem.exists(a) ? mem[a] : 32'hxxxx_xxxx,
            pat(src + 32'(4 * i)));
    end
  endtask

  int g0;
  bit got;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req", 32'(m_req_o), 32'h0);
    check("rst_we", 32'(m_we_o), 32'h0);
    check("rst_be", 32'(m_be_o), 32'h0);
    check("rst_addr", m_addr_o, 32'h0);
    check("rst_wdata", m_wdata_o, 32'h0);
    check("rst_dvalid", 32'(DATA_VALID), 32'h0);
    check("rst_dout", DATA_OUT, 32'h0);
    check("rst_wack", 32'(WACK), 32'h0);
`ifdef DMA_IRQ_EN
    check("rst_irq", 32'(irq_o), 32'h0);
`endif
    rst_ni = 1'b1;
    @(negedge clk);
    read_chk("rst_src", A_SRC, 32'h0);
    read_chk("rst_len", A_LEN, 32'h0);
    read_chk("rst_count", A_CNT, 32'h0);
    read_chk("rst_status", A_STAT, 32'h0);

    // Byte enables and forced alignment
    reg_write(A_SRC, 32'hFFFF_FFFF, 4'hF);
    reg_write(A_SRC, 32'h1234_567B, 4'b0101);
    read_chk("src_be_merge", A_SRC, 32'hFF34_FF78);
    read_chk("unmapped_reg", 4'd9, 32'h0);

    // 1: plain 4-word copy
    mem.delete();
    rd_log.delete();
    plan(32'h8000_0100, 32'h8000_0200, 4, 99);
    start_xfer(32'h8000_0100, 32'h8000_0200, 32'd4, 32'h1);
    wait_idle();
    end_regs("t1", 32'h2, 32'h0);
    mem_chk("t1", 32'h8000_0100, 32'h8000_0200, 4);
    check("t1_nreads", rd_log.size(), 4);
    check("t1_rd0", rd_log[0], 32'h8000_0100);
    check("t1_rd3", rd_log[3], 32'h8000_010C);

    // 2: zero length, DONE one cycle after WACK
    reg_write(A_STAT, 32'h2, 4'hF);
    read_chk("t2_w1c", A_STAT, 32'h0);
    g0 = n_grants;
    reg_write(A_LEN, 32'h0, 4'hF);
    reg_write(A_CTRL, 32'h1, 4'hF);
    read_chk("t2_not_yet", A_STAT, 32'h0);
    read_chk("t2_done", A_STAT, 32'h2);
    repeat (4) @(negedge clk);
    check("t2_no_grants", n_grants, g0);

    // 3: grant withheld, write while busy ignored
    mem.delete();
    gnt_delay = 5;
    plan(32'h8000_0100, 32'h8000_0200, 4, 99);
    start_xfer(32'h8000_0100, 32'h8000_0200, 32'd4, 32'h1);
    repeat (2) @(negedge clk);
    reg_write(A_SRC, 32'hDEAD_BEEC, 4'hF);
    wait_idle();
    gnt_delay = 0;
    end_regs("t3", 32'h2, 32'h0);
    mem_chk("t3", 32'h8000_0100, 32'h8000_0200, 4);
    read_chk("t3_src_kept", A_SRC, 32'h8000_0100);

    // 4: bus error on the second read
    mem.delete();
    err_beat = beat_no + 2;
    plan(32'h0000_1000, 32'h0000_2000, 4, 3);
    start_xfer(32'h0000_1000, 32'h0000_2000, 32'd4, 32'h1);
    wait_idle();
    err_beat = -1;
    end_regs("t4", 32'h4, 32'h3);
    check("t4_req_low", 32'(m_req_o), 32'h0);
    check("t4_one_write", mem.size(), 1);

    // 5: abort during the third read's wait
    mem.delete();
    rsp_delay = 4;
    plan(32'h0000_3000, 32'h0000_4000, 8, 5);
    g0 = n_grants;
    start_xfer(32'h0000_3000, 32'h0000_4000, 32'd8, 32'h1);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (n_grants >= g0 + 5) begin
        got = 1'b1;
        break;
      end
    end
    check("t5_grant_wait", 32'(got), 32'h1);
    @(negedge clk);
    reg_write(A_CTRL, 32'h2, 4'hF);
    wait_idle();
    rsp_delay = 1;
    end_regs("t5", 32'h8, 32'h6);

    // 6: source pointer wraps, optional interrupt
    mem.delete();
    rd_log.delete();
    reg_write(A_CTRL, 32'h4, 4'hF);
`ifdef DMA_IRQ_EN
    read_chk("t6_irq_en", A_CTRL, 32'h4);
`else
    read_chk("t6_irq_en", A_CTRL, 32'h0);
`endif
    plan(32'hFFFF_FFF8, 32'h0000_0100, 3, 99);
`ifdef DMA_IRQ_EN
    start_xfer(32'hFFFF_FFF8, 32'h0000_0100, 32'd3, 32'h5);
    check("t6_irq_idle", 32'(irq_o), 32'h0);
`else
    start_xfer(32'hFFFF_FFF8, 32'h0000_0100, 32'd3, 32'h1);
`endif
    wait_idle();
    end_regs("t6", 32'h2, 32'h0);
    check("t6_nreads", rd_log.size(), 3);
    check("t6_rd0", rd_log[0], 32'hFFFF_FFF8);
    check("t6_rd1", rd_log[1], 32'hFFFF_FFFC);
    check("t6_rd2", rd_log[2], 32'h0000_0000);
    mem_chk("t6", 32'hFFFF_FFF8, 32'h0000_0100, 3);
`ifdef DMA_IRQ_EN
    check("t6_irq_set", 32'(irq_o), 32'h1);
    reg_write(A_STAT, 32'h2, 4'hF);
    check("t6_irq_clr", 32'(irq_o), 32'h0);
`endif

    // 7: reset in the middle of a request
    gnt_delay = 30;
    plan(32'h0000_0200, 32'h0000_0300, 4, 99);
    start_xfer(32'h0000_0200, 32'h0000_0300, 32'd4, 32'h1);
    repeat (4) @(negedge clk);
    check("t7_req_high", 32'(m_req_o), 32'h1);
    #2 rst_ni = 1'b0;
    #1 check("t7_req_async", 32'(m_req_o), 32'h0);
    exp_q.delete();
    @(negedge clk);
    #1 rst_ni = 1'b1;
    gnt_delay = 0;
    @(negedge clk);
    read_chk("t7_status", A_STAT, 32'h0);
    read_chk("t7_count", A_CNT, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
